// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus transfer arbiter: state codes, default sizes and the register index decoder.
package bus_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    localparam int NUM_REGS_DEF = 16;
    localparam int IDX_W_DEF    = 4;
    localparam int DEC_MAX      = 256;

    // Callers keep only their low NUM_REGS bits, so out-of-range indices decode to all-zero.
    function automatic logic [DEC_MAX-1:0] onehot_dec(input logic [7:0] idx);
        logic [DEC_MAX-1:0] v;
        v = {{(DEC_MAX-1){1'b0}}, 1'b1};
        return v << idx;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);
    logic          w_found;
    logic          w_hit;
    logic [PW-1:0] w_j;
    logic [PW-1:0] w_idx;

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_j     = {PW{1'b0}};
        w_idx   = {PW{1'b0}};
        for (int k = 0; k < N; k++) begin
            w_j     = PW'((int'(i_ptr) + k) % N);
            w_hit   = !w_found && i_req[w_j];
            w_idx   = w_hit ? w_j : w_idx;
            w_found = w_found | w_hit;
        end
    end

    assign o_any  = w_found;
    assign o_idx  = w_idx;
    assign o_pick = w_found ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : {N{1'b0}};
endmodule

// File: rtl/bus_xfer_arbiter.sv
// Round-robin owner of the internal CPU bus: Rout/BAout drive phase, then Rin latch phase with ack.
// Optional macro BUS_XFER_STATS_EN adds the xfer_count and stall_count outputs.
module bus_xfer_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] src_idx,
    input  logic [NUM_REQ*IDX_W-1:0] dst_idx,
    input  logic [NUM_REQ-1:0]       ba_mode,
    input  logic                     stall_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REGS-1:0]      rout,
    output logic [NUM_REGS-1:0]      rin,
    output logic                     BAout,
    output logic                     busy
`ifdef BUS_XFER_STATS_EN
    ,
    output logic [31:0]              xfer_count,
    output logic [31:0]              stall_count
`endif
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [OW-1:0]       r_ptr;
    logic [OW-1:0]       r_owner;
    logic [IDX_W-1:0]    r_src;
    logic [IDX_W-1:0]    r_dst;
    logic                r_ba;
    logic                w_take;
    logic                w_any;
    logic [OW-1:0]       w_ptr_after;
    logic [OW-1:0]       w_pick_ptr;
    logic [OW-1:0]       w_pick_idx;
    logic [NUM_REQ-1:0]  w_pick_req;
    logic [NUM_REQ-1:0]  w_pick_oh;
    logic [NUM_REQ-1:0]  w_owner_oh;
    logic [IDX_W-1:0]    w_src_sel;
    logic [IDX_W-1:0]    w_dst_sel;
    logic [IDX_W-1:0]    w_src_n;
    logic [IDX_W-1:0]    w_dst_n;
    logic                w_ba_n;
    logic [NUM_REQ-1:0]  w_grant_n;
    logic [NUM_REGS-1:0] w_src_dec;
    logic [NUM_REGS-1:0] w_dst_dec;
    logic [NUM_REQ-1:0]  w_grant_d;
    logic [NUM_REQ-1:0]  w_ack_d;
    logic [NUM_REGS-1:0] w_rout_d;
    logic [NUM_REGS-1:0] w_rin_d;
    logic                w_ba_d;
    logic                w_busy_d;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REGS-1:0] r_rout;
    logic [NUM_REGS-1:0] r_rin;
    logic                r_baout;
    logic                r_busy;

    // The owner's request counts as consumed during its ack cycle, so it is masked out of re-arbitration.
    assign w_owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_ptr_after = (r_owner == OW'(NUM_REQ - 1)) ? {OW{1'b0}} : r_owner + {{(OW-1){1'b0}}, 1'b1};
    assign w_pick_ptr  = (r_state == LATCH) ? w_ptr_after : r_ptr;
    assign w_pick_req  = (r_state == LATCH) ? (req & ~w_owner_oh) : req;

    rr_pick #(.N(NUM_REQ), .PW(OW)) u_pick (
        .i_req  (w_pick_req),
        .i_ptr  (w_pick_ptr),
        .o_pick (w_pick_oh),
        .o_idx  (w_pick_idx),
        .o_any  (w_any)
    );

    assign w_src_sel = src_idx[IDX_W*int'(w_pick_idx) +: IDX_W];
    assign w_dst_sel = dst_idx[IDX_W*int'(w_pick_idx) +: IDX_W];
    assign w_src_n   = w_take ? w_src_sel : r_src;
    assign w_dst_n   = w_take ? w_dst_sel : r_dst;
    assign w_ba_n    = w_take ? ba_mode[w_pick_idx] : r_ba;
    assign w_grant_n = w_take ? w_pick_oh : w_owner_oh;
    assign w_src_dec = NUM_REGS'(onehot_dec(8'(w_src_n)));
    assign w_dst_dec = NUM_REGS'(onehot_dec(8'(w_dst_n)));

    // State register, round-robin pointer and the fields latched at each grant decision.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
            r_ptr   <= {OW{1'b0}};
            r_owner <= {OW{1'b0}};
            r_src   <= {IDX_W{1'b0}};
            r_dst   <= {IDX_W{1'b0}};
            r_ba    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == LATCH) begin
                r_ptr <= w_ptr_after;
            end
            if (w_take) begin
                r_owner <= w_pick_idx;
                r_src   <= w_src_sel;
                r_dst   <= w_dst_sel;
                r_ba    <= ba_mode[w_pick_idx];
            end
        end
    end

    // Next-state logic; stall only matters when starting from idle or while driving.
    always_comb begin
        w_state_nxt = IDLE;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && !stall_in) begin
                    w_state_nxt = DRIVE;
                    w_take      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DRIVE: w_state_nxt = stall_in ? DRIVE : LATCH;
            LATCH: begin
                if (w_any) begin
                    w_state_nxt = DRIVE;
                    w_take      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so nothing is combinational from inputs.
    always_comb begin
        w_grant_d = {NUM_REQ{1'b0}};
        w_ack_d   = {NUM_REQ{1'b0}};
        w_rout_d  = {NUM_REGS{1'b0}};
        w_rin_d   = {NUM_REGS{1'b0}};
        w_ba_d    = 1'b0;
        w_busy_d  = 1'b0;
        case (w_state_nxt)
            DRIVE: begin
                w_grant_d = w_grant_n;
                w_rout_d  = w_src_dec;
                w_ba_d    = w_ba_n;
                w_busy_d  = 1'b1;
            end
            LATCH: begin
                w_grant_d = w_grant_n;
                w_ack_d   = w_grant_n;
                w_rout_d  = w_src_dec;
                w_rin_d   = w_dst_dec;
                w_ba_d    = w_ba_n;
                w_busy_d  = 1'b1;
            end
            default: w_busy_d = 1'b0;
        endcase
    end

    // Output registers; clear drops them without waiting for a clock edge.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_grant <= {NUM_REQ{1'b0}};
            r_ack   <= {NUM_REQ{1'b0}};
            r_rout  <= {NUM_REGS{1'b0}};
            r_rin   <= {NUM_REGS{1'b0}};
            r_baout <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_grant <= w_grant_d;
            r_ack   <= w_ack_d;
            r_rout  <= w_rout_d;
            r_rin   <= w_rin_d;
            r_baout <= w_ba_d;
            r_busy  <= w_busy_d;
        end
    end

    assign grant = r_grant;
    assign ack   = r_ack;
    assign rout  = r_rout;
    assign rin   = r_rin;
    assign BAout = r_baout;
    assign busy  = r_busy;

`ifdef BUS_XFER_STATS_EN
    logic [31:0] r_xfer_cnt;
    logic [31:0] r_stall_cnt;

    // Counters follow the registered state, matching the visible ack and stalled-drive cycles.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_xfer_cnt  <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (r_state == LATCH) begin
                r_xfer_cnt <= r_xfer_cnt + 32'd1;
            end
            if ((r_state == DRIVE) && stall_in) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign xfer_count  = r_xfer_cnt;
    assign stall_count = r_stall_cnt;
`endif
endmodule
